// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, op codes, error codes
// and the request decode helper.
package dmem_pkg;

    localparam int unsigned CNT_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_CONFLICT = 2'b10,
        ERR_PARITY   = 2'b11
    } err_e;

    typedef struct packed {
        op_e  op;
        err_e err;
    } req_meta_t;

    // Misalignment outranks the read/write conflict.
    function automatic req_meta_t decode_req(input logic [1:0] addr_lsb,
                                             input logic       re,
                                             input logic       we);
        req_meta_t m;
        m.op = we ? OP_WR : OP_RD;
        if (addr_lsb != 2'b00)
            m.err = ERR_MISALIGN;
        else if (re && we)
            m.err = ERR_CONFLICT;
        else
            m.err = ERR_OK;
        return m;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port bundle; parity_inject exists only when DMEM_PARITY_EN is defined.
interface data_mem_responder_if #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 32
);
    logic [ADDR_BITS-1:0] Data_MEM_Address;
    logic                 Data_MEM_Read_Enable;
    logic                 Data_MEM_Write_Enable;
    logic [DATA_BITS-1:0] Data_MEM_Write_Data;
    logic [DATA_BITS-1:0] Data_MEM_Read_Data;
    logic                 mem_ready;
    logic                 mem_ack;
    logic [1:0]           mem_err_code;
`ifdef DMEM_PARITY_EN
    logic                 parity_inject;

    modport master (
        output Data_MEM_Address, Data_MEM_Read_Enable, Data_MEM_Write_Enable,
               Data_MEM_Write_Data, parity_inject,
        input  Data_MEM_Read_Data, mem_ready, mem_ack, mem_err_code
    );

    modport slave (
        input  Data_MEM_Address, Data_MEM_Read_Enable, Data_MEM_Write_Enable,
               Data_MEM_Write_Data, parity_inject,
        output Data_MEM_Read_Data, mem_ready, mem_ack, mem_err_code
    );
`else
    modport master (
        output Data_MEM_Address, Data_MEM_Read_Enable, Data_MEM_Write_Enable,
               Data_MEM_Write_Data,
        input  Data_MEM_Read_Data, mem_ready, mem_ack, mem_err_code
    );

    modport slave (
        input  Data_MEM_Address, Data_MEM_Read_Enable, Data_MEM_Write_Enable,
               Data_MEM_Write_Data,
        output Data_MEM_Read_Data, mem_ready, mem_ack, mem_err_code
    );
`endif
endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word array: registered read of idx every cycle, write when we.
module dmem_array #(
    parameter int unsigned IDX_BITS  = 14,
    parameter int unsigned WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  idx,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [0:(1 << IDX_BITS) - 1];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
        rdata <= mem[idx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: IDLE/ACCESS/DONE with WAIT_STATES wait cycles.
// Optional DMEM_PARITY_EN adds an even-parity bit per word and error code 11 on mismatch.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 16,
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_BITS = ADDR_BITS - 2;
`ifdef DMEM_PARITY_EN
    localparam int unsigned WORD_BITS = DATA_BITS + 1;
`else
    localparam int unsigned WORD_BITS = DATA_BITS;
`endif

    state_e               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [IDX_BITS-1:0]  idx_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [DATA_BITS-1:0] rd_data_q;
    req_meta_t            meta_q, meta_c;
    logic                 ready_q;
    logic                 ack_q, ack_d;
    err_e                 code_q, code_d;
    logic                 capture_c;
    logic                 array_we_c;
    logic                 rd_load_c;
    logic [IDX_BITS-1:0]  array_idx_c;
    logic [WORD_BITS-1:0] array_wdata_c;
    logic [WORD_BITS-1:0] array_rdata;
`ifdef DMEM_PARITY_EN
    logic                 inject_q;
`endif

    // Array reads the live address in IDLE so read data is ready even with zero wait states.
    always_comb begin
        array_idx_c = (state_q == ST_IDLE) ? bus.Data_MEM_Address[ADDR_BITS-1:2] : idx_q;
`ifdef DMEM_PARITY_EN
        array_wdata_c = {(^wdata_q) ^ inject_q, wdata_q};
`else
        array_wdata_c = wdata_q;
`endif
    end

    dmem_array #(
        .IDX_BITS  (IDX_BITS),
        .WORD_BITS (WORD_BITS)
    ) u_array (
        .clk   (clk),
        .we    (array_we_c),
        .idx   (array_idx_c),
        .wdata (array_wdata_c),
        .rdata (array_rdata)
    );

    // Next-state, wait counter and completion decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_c  = 1'b0;
        array_we_c = 1'b0;
        rd_load_c  = 1'b0;
        ack_d      = 1'b0;
        code_d     = ERR_OK;
        meta_c     = decode_req(bus.Data_MEM_Address[1:0],
                                bus.Data_MEM_Read_Enable, bus.Data_MEM_Write_Enable);
        case (state_q)
            ST_IDLE: begin
                if (bus.Data_MEM_Read_Enable || bus.Data_MEM_Write_Enable) begin
                    capture_c = 1'b1;
                    cnt_d     = CNT_BITS'(WAIT_STATES);
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end else begin
                    state_d = ST_DONE;
                    ack_d   = 1'b1;
                    code_d  = meta_q.err;
                    if (meta_q.err == ERR_OK) begin
                        if (meta_q.op == OP_WR) begin
                            array_we_c = 1'b1;
                        end else begin
                            rd_load_c = 1'b1;
`ifdef DMEM_PARITY_EN
                            if (^array_rdata)
                                code_d = ERR_PARITY;
`endif
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, capture and registered outputs; array contents survive reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            meta_q    <= '{op: OP_RD, err: ERR_OK};
            rd_data_q <= '0;
            ready_q   <= 1'b1;
            ack_q     <= 1'b0;
            code_q    <= ERR_OK;
`ifdef DMEM_PARITY_EN
            inject_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE);
            ack_q   <= ack_d;
            code_q  <= code_d;
            if (capture_c) begin
                idx_q    <= bus.Data_MEM_Address[ADDR_BITS-1:2];
                wdata_q  <= bus.Data_MEM_Write_Data;
                meta_q   <= meta_c;
`ifdef DMEM_PARITY_EN
                inject_q <= bus.parity_inject;
`endif
            end
            if (rd_load_c)
                rd_data_q <= array_rdata[DATA_BITS-1:0];
        end
    end

    assign bus.Data_MEM_Read_Data = rd_data_q;
    assign bus.mem_ready          = ready_q;
    assign bus.mem_ack            = ack_q;
    assign bus.mem_err_code       = code_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with 2 wait states, one with 0.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_BITS(16), .DATA_BITS(32)) bus2 ();
    data_mem_responder_if #(.ADDR_BITS(16), .DATA_BITS(32)) bus0 ();

    data_mem_responder #(.ADDR_BITS(16), .DATA_BITS(32), .WAIT_STATES(2)) dut_ws2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    data_mem_responder #(.ADDR_BITS(16), .DATA_BITS(32), .WAIT_STATES(0)) dut_ws0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl_mem [int];
    bit          mdl_par [int];
    logic [31:0] last_rd [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 0) ? bus2.Data_MEM_Read_Data : bus0.Data_MEM_Read_Data;
    endfunction
    function automatic logic [31:0] get_err(input int sel);
        return (sel == 0) ? 32'(bus2.mem_err_code) : 32'(bus0.mem_err_code);
    endfunction
    function automatic logic [31:0] get_ack(input int sel);
        return (sel == 0) ? 32'(bus2.mem_ack) : 32'(bus0.mem_ack);
    endfunction
    function automatic logic [31:0] get_ready(input int sel);
        return (sel == 0) ? 32'(bus2.mem_ready) : 32'(bus0.mem_ready);
    endfunction

    task automatic set_req(input int sel, input logic [15:0] addr, input logic re,
                           input logic we, input logic [31:0] wd, input logic inj);
        if (sel == 0) begin
            bus2.Data_MEM_Address      = addr;
            bus2.Data_MEM_Read_Enable  = re;
            bus2.Data_MEM_Write_Enable = we;
            bus2.Data_MEM_Write_Data   = wd;
`ifdef DMEM_PARITY_EN
            bus2.parity_inject         = inj;
`endif
        end else begin
            bus0.Data_MEM_Address      = addr;
            bus0.Data_MEM_Read_Enable  = re;
            bus0.Data_MEM_Write_Enable = we;
            bus0.Data_MEM_Write_Data   = wd;
`ifdef DMEM_PARITY_EN
            bus0.parity_inject         = inj;
`endif
        end
        if (inj) begin end
    endtask

    // Pop the oldest expectation whenever either responder acknowledges.
    task automatic score(input int sel);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_ack", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_sel"}, 32'(sel), 32'(e.sel));
            check({e.tag, "_err"}, get_err(sel), e.err);
            check({e.tag, "_rdata"}, get_rd(sel), e.data);
        end
    endtask

    always @(negedge clk) begin
        if (bus2.mem_ack) score(0);
        if (bus0.mem_ack) score(1);
    end

    // Drive one request at a negedge, model the result, wait for the ack and check timing.
    task automatic run_req(input int sel, input string tag, input logic [15:0] addr,
                           input logic re, input logic we, input logic [31:0] wd,
                           input logic inj);
        exp_t e;
        int   key;
        int   ws;
        int   lat;
        ws  = (sel == 0) ? 2 : 0;
        key = sel * 65536 + int'(addr[15:2]);
        e.sel = sel;
        e.tag = tag;
        if (addr[1:0] != 2'b00)
            e.err = 32'd1;
        else if (re && we)
            e.err = 32'd2;
        else
            e.err = 32'd0;
        if (e.err == 32'd0) begin
            if (we) begin
                mdl_mem[key] = wd;
                mdl_par[key] = inj;
            end else begin
                last_rd[sel] = mdl_mem[key];
                if (mdl_par[key]) e.err = 32'd3;
            end
        end
        e.data = last_rd[sel];
        check({tag, "_ready_pre"}, get_ready(sel), 32'd1);
        sb_q.push_back(e);
        set_req(sel, addr, re, we, wd, inj);
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, "_ready_busy"}, get_ready(sel), 32'd0);
            if (get_ack(sel) == 32'd1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(ws + 2));
        check({tag, "_ready_done"}, get_ready(sel), 32'd0);
        set_req(sel, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check({tag, "_ack_pulse"}, get_ack(sel), 32'd0);
        check({tag, "_ready_idle"}, get_ready(sel), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        rst = 1'b0;
        set_req(0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        set_req(1, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", get_ready(s), 32'd1);
            check("rst_ack", get_ack(s), 32'd0);
            check("rst_err", get_err(s), 32'd0);
            check("rst_rdata", get_rd(s), 32'd0);
        end

        run_req(0, "ws2_wr10", 16'h0010, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        run_req(0, "ws2_rd10", 16'h0010, 1'b1, 1'b0, 32'h0, 1'b0);

        run_req(1, "ws0_wr04", 16'h0004, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
        run_req(1, "ws0_rd04", 16'h0004, 1'b1, 1'b0, 32'h0, 1'b0);

        run_req(0, "mis_rd13", 16'h0013, 1'b1, 1'b0, 32'h0, 1'b0);
        run_req(0, "mis_wr11", 16'h0011, 1'b0, 1'b1, 32'h00000055, 1'b0);
        run_req(0, "chk_rd10", 16'h0010, 1'b1, 1'b0, 32'h0, 1'b0);

        run_req(0, "wr20", 16'h0020, 1'b0, 1'b1, 32'h0BADC0DE, 1'b0);
        run_req(0, "conf20", 16'h0020, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        run_req(0, "mis_conf22", 16'h0022, 1'b1, 1'b1, 32'h12121212, 1'b0);
        run_req(0, "rd20", 16'h0020, 1'b1, 1'b0, 32'h0, 1'b0);

        run_req(1, "top_wr", 16'hFFFC, 1'b0, 1'b1, 32'hA5A5_5A5A, 1'b0);
        run_req(1, "top_rd", 16'hFFFC, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom_range(1, 255) * 4);
            d = $urandom;
            run_req(1, "rnd_wr", a, 1'b0, 1'b1, d, 1'b0);
            run_req(1, "rnd_rd", a, 1'b1, 1'b0, 32'h0, 1'b0);
        end

        // Abort a write mid-access: no ack, old contents kept.
        set_req(0, 16'h0010, 1'b0, 1'b1, 32'h12345678, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("abort_ack_in_rst", get_ack(0), 32'd0);
        rst = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_ack", get_ack(0), 32'd0);
        end
        check("abort_ready", get_ready(0), 32'd1);
        check("abort_rdata_clr", get_rd(0), 32'd0);
        run_req(0, "abort_rd10", 16'h0010, 1'b1, 1'b0, 32'h0, 1'b0);

`ifdef DMEM_PARITY_EN
        run_req(0, "par_wr_inj", 16'h0040, 1'b0, 1'b1, 32'h00000001, 1'b1);
        run_req(0, "par_rd_inj", 16'h0040, 1'b1, 1'b0, 32'h0, 1'b0);
        run_req(0, "par_wr_ok", 16'h0040, 1'b0, 1'b1, 32'h00000001, 1'b0);
        run_req(0, "par_rd_ok", 16'h0040, 1'b1, 1'b0, 32'h0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
